s2p_frame_deser: RTL
====================

// Module: s2p_frame_deser
// PURPOSE
//   Parametrised serial-to-parallel deserialiser for the block-array ADC readout path.
//   Captures a framed serial stream of NUM_CH words of BITS_ADC bits each. Words are stored in a shadow bank.
//   The complete frame is published atomically to a flat output bus.
//   Adds bit-order select, per-word strobes, frame-done/error flags and an error counter.
//   Sits between the chip serial readout pin and the per-block channel register map.
// PARAMETERS
//   BITS_ADC  12  bits per ADC word (>=2)
//   NUM_CH    32  words per frame (>=2); channel counter wraps at NUM_CH-1
//   ERR_W     8   width of saturating frame-error counter
// PORTS
//   clk         in   1                rising-edge clock
//   rst_n       in   1                synchronous reset, active-low
//   s_data      in   1                serial data bit, sampled every clk while frame enabled
//   data_valid  in   1                frame enable, ACTIVE-LOW (0 = shifting)
//   msb_first   in   1                1: MSB-first word order; 0: LSB-first; sampled at frame start
//   word_valid  out  1                1-cycle strobe: word_data/word_ch hold a completed word
//   word_data   out  BITS_ADC         last completed word
//   word_ch     out  $clog2(NUM_CH)   channel index of word_data (receive order, 0 = first)
//   frame_done  out  1                1-cycle strobe: data_out updated with a full frame
//   frame_err   out  1                1-cycle strobe: frame aborted before completion
//   err_cnt     out  ERR_W            saturating count of aborted frames
//   data_out    out  NUM_CH*BITS_ADC  last complete frame; channel k at [k*BITS_ADC +: BITS_ADC]
// BEHAVIOUR
//   - Reset: synchronous when rst_n==0 at a clk edge; dominates all other events.
//     All outputs, shadow bank, counters and the shift buffer are cleared to 0.
//   - Shift: each clk with data_valid==0 samples s_data.
//     LSB-first: buf <= {s_data, buf[B-1:1]}. MSB-first: buf <= {buf[B-2:0], s_data}.
//   - bit_cnt counts 0..BITS_ADC-1. At bit_cnt==BITS_ADC-1 the word completes, including the current bit:
//     - next cycle: word_valid=1, word_data=word, word_ch=ch_cnt; the word is written to shadow[ch_cnt].
//     - bit_cnt returns to 0 and ch_cnt increments.
//     - Latency: 1 clk from sampling the last bit.
//   - Frame end: when the word completes with ch_cnt==NUM_CH-1:
//     - data_out <= shadow, with channel NUM_CH-1 taken from the new word.
//     - frame_done=1 in the same cycle as that word_valid.
//     - ch_cnt wraps to 0. Back-to-back frames need no idle cycle.
//   - Mode latch: msb_first is captured when data_valid==0 and bit_cnt==0 and ch_cnt==0.
//     Changes mid-frame are ignored until the next frame start.
//   - Abort: data_valid==1 while (bit_cnt!=0 or ch_cnt!=0):
//     - next cycle: frame_err=1 and err_cnt+1 (saturates at all-ones).
//     - bit_cnt and ch_cnt clear; partial shadow contents are discarded.
//     - data_out keeps the previous frame; no word_valid is issued for the partial word.
//   - Idle: data_valid==1 at a word boundary with ch_cnt==0 gives no error and no state change.
//   - Frame ending exactly as data_valid rises: frame completes normally; no frame_err.
//   - Strobes are single-cycle. Outputs are registered; there are no combinational in->out paths.
// STRUCTURE
//   - Package s2p_pkg: localparams BIT_CNT_W=$clog2(BITS_ADC), CH_CNT_W=$clog2(NUM_CH).
//     Also holds the bit-order enum (LSB_FIRST=0, MSB_FIRST=1).
//   - Sub-module s2p_shift_unit: shift buffer, bit_cnt, mode latch, word_done pulse.
//   - Top: channel counter, shadow bank, publish logic, error counter, strobes.
//   - Channel-to-block remapping (reverse order, ch/blk naming) is left to the top-level wrapper.
// TESTING  (bench uses BITS_ADC=12, NUM_CH=4 unless noted)
//   1. LSB-first frame 0x123,0x456,0x789,0xABC; data_valid=0 for 48 clk.
//      -> word_valid x4 with word_ch 0..3.
//      -> frame_done once, with data_out={0xABC,0x789,0x456,0x123}.
//   2. Same words MSB-first, with msb_first toggled mid-frame.
//      -> identical data_out; the toggle has no effect until the next frame.
//   3. Abort after 2 words + 5 bits.
//      -> frame_err=1, err_cnt=1, no frame_done, data_out unchanged from test 1.
//      -> a following full frame publishes correctly.
//   4. Three back-to-back frames with no idle cycle.
//      -> frame_done every 48 clk, with each data_out matching its frame.
//   5. rst_n=0 for 1 clk mid-word, then a full frame.
//      -> all outputs 0 after reset; the next frame starts at ch 0 bit 0 and publishes correctly.
//   6. 300 aborted frames with ERR_W=8 -> err_cnt saturates at 0xFF.
//      Also run NUM_CH=32, BITS_ADC=16: random frames match the scoreboard.

Source files
------------

// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared types and width helpers for the serial-to-parallel frame deserialiser
package s2p_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_BITS_ADC = 12;
  localparam int DEF_NUM_CH   = 32;
  localparam int BIT_CNT_W    = cnt_w(DEF_BITS_ADC);
  localparam int CH_CNT_W     = cnt_w(DEF_NUM_CH);

endpackage

// File: rtl/s2p_shift_unit.sv
// rtl/s2p_shift_unit.sv - word shift buffer, bit counter and bit-order latch
module s2p_shift_unit
  import s2p_pkg::*;
#(
  parameter int BITS_ADC = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_s_data,
  input  logic                i_data_valid,
  input  logic                i_msb_first,
  input  logic                i_ch_zero,
  output logic [BITS_ADC-1:0] o_word,
  output logic                o_word_done,
  output logic                o_mid_word
);

  localparam int              BCW      = cnt_w(BITS_ADC);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(BITS_ADC - 1);

  logic [BITS_ADC-1:0] r_buf;
  logic [BITS_ADC-1:0] w_buf_nxt;
  logic [BCW-1:0]      r_bit_cnt;
  bit_order_e          r_mode;
  bit_order_e          w_mode;
  logic                w_shift;

  // The first bit of a frame already uses the freshly sampled order.
  always_comb begin
    w_shift   = !i_data_valid;
    w_mode    = r_mode;
    w_buf_nxt = r_buf;
    if (r_bit_cnt == '0 && i_ch_zero) begin
      w_mode = bit_order_e'(i_msb_first);
    end
    if (w_shift) begin
      if (w_mode == MSB_FIRST) begin
        w_buf_nxt = {r_buf[BITS_ADC-2:0], i_s_data};
      end else begin
        w_buf_nxt = {i_s_data, r_buf[BITS_ADC-1:1]};
      end
    end
  end

  assign o_word      = w_buf_nxt;
  assign o_word_done = w_shift && (r_bit_cnt == LAST_BIT);
  assign o_mid_word  = (r_bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_bit_cnt <= '0;
      r_mode    <= LSB_FIRST;
    end else if (w_shift) begin
      r_buf     <= w_buf_nxt;
      r_mode    <= w_mode;
      r_bit_cnt <= o_word_done ? '0 : r_bit_cnt + 1'b1;
    end else begin
      r_bit_cnt <= '0;
    end
  end

endmodule

// File: rtl/s2p_frame_deser.sv
// rtl/s2p_frame_deser.sv - framed serial-to-parallel ADC deserialiser with atomic frame publish
module s2p_frame_deser
  import s2p_pkg::*;
#(
  parameter int BITS_ADC = 12,
  parameter int NUM_CH   = 32,
  parameter int ERR_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_data,
  input  logic                       data_valid,
  input  logic                       msb_first,
  output logic                       word_valid,
  output logic [BITS_ADC-1:0]        word_data,
  output logic [$clog2(NUM_CH)-1:0]  word_ch,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [ERR_W-1:0]           err_cnt,
  output logic [NUM_CH*BITS_ADC-1:0] data_out
);

  localparam int             CCW     = $clog2(NUM_CH);
  localparam logic [CCW-1:0] LAST_CH = CCW'(NUM_CH - 1);

  logic [BITS_ADC-1:0]        w_word;
  logic                       w_word_done;
  logic                       w_mid_word;
  logic                       w_ch_zero;
  logic                       w_last_ch;
  logic                       w_abort;

  logic [CCW-1:0]             r_ch_cnt;
  logic [BITS_ADC-1:0]        r_shadow [NUM_CH];
  logic                       r_word_valid;
  logic [BITS_ADC-1:0]        r_word_data;
  logic [CCW-1:0]             r_word_ch;
  logic                       r_frame_done;
  logic                       r_frame_err;
  logic [ERR_W-1:0]           r_err_cnt;
  logic [NUM_CH*BITS_ADC-1:0] r_data_out;

  s2p_shift_unit #(
    .BITS_ADC (BITS_ADC)
  ) u_shift (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_s_data     (s_data),
    .i_data_valid (data_valid),
    .i_msb_first  (msb_first),
    .i_ch_zero    (w_ch_zero),
    .o_word       (w_word),
    .o_word_done  (w_word_done),
    .o_mid_word   (w_mid_word)
  );

  assign w_ch_zero = (r_ch_cnt == '0);
  assign w_last_ch = (r_ch_cnt == LAST_CH);
  // Enable dropping at a word boundary with ch 0 is plain idle, not an abort.
  assign w_abort   = data_valid && (w_mid_word || !w_ch_zero);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch_cnt     <= '0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_ch    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_cnt    <= '0;
      r_data_out   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_word_done) begin
        r_word_valid       <= 1'b1;
        r_word_data        <= w_word;
        r_word_ch          <= r_ch_cnt;
        r_shadow[r_ch_cnt] <= w_word;
        if (w_last_ch) begin
          r_ch_cnt     <= '0;
          r_frame_done <= 1'b1;
          // Shadow slot of the last channel is not written yet; take it from the new word.
          for (int k = 0; k < NUM_CH - 1; k++) begin
            r_data_out[k*BITS_ADC +: BITS_ADC] <= r_shadow[k];
          end
          r_data_out[(NUM_CH-1)*BITS_ADC +: BITS_ADC] <= w_word;
        end else begin
          r_ch_cnt <= r_ch_cnt + 1'b1;
        end
      end else if (w_abort) begin
        r_ch_cnt    <= '0;
        r_frame_err <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign word_valid = r_word_valid;
  assign word_data  = r_word_data;
  assign word_ch    = r_word_ch;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign err_cnt    = r_err_cnt;
  assign data_out   = r_data_out;

endmodule
